// File: rtl/cpu_mul_sequencer.sv
// cpu_mul_sequencer: multi-cycle 32-bit integer multiply sequencer.
// Drives a registered 16x16 partial-product cell once for MUL (low word)
// and twice for MULXUU/MULXSU/MULXSS (high word), then pulses done.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0; operands and op are latched on that edge. start is ignored
// while busy=1 (including the FINISH cycle). done is a one-cycle pulse
// and result is valid in that cycle and held until the next done.
module cpu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // State is kept as a named enum so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Only the upper 17 bits of mid and the carry out of the low word are
  // needed by the second pass; together with hh they form P[63:32].
  logic [16:0] mid_hi_q;
  logic        lo_carry_q;

  logic [32:0] mid_sum;
  logic [32:0] low_sum;
  logic [31:0] high_raw;
  logic [31:0] corr_b;
  logic [31:0] corr_a;
  logic [31:0] high_word;

  logic accept;

  assign accept = (state == S_IDLE) && start;

  // First-pass arithmetic: mid = p2 + p3 (carry kept), low word of P.
  assign mid_sum = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign low_sum = {1'b0, cell_p1} + {1'b0, mid_sum[15:0], 16'h0000};

  // Second pass: P[63:32] = hh + mid[32:16] + carry out of the low word,
  // then signed corrections for a negative A and/or B.
  assign high_raw  = cell_p1 + {15'h0000, mid_hi_q} + {31'h0, lo_carry_q};
  assign corr_b    = (op_q[1] && a_q[31]) ? b_q : 32'h0;
  assign corr_a    = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'h0;
  assign high_word = high_raw - corr_b - corr_a;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ISSUE1;
      S_ISSUE1: state_next = S_WAIT1;
      S_WAIT1:  state_next = (op_q == OP_MUL) ? S_FINISH : S_ISSUE2;
      S_ISSUE2: state_next = S_WAIT2;
      S_WAIT2:  state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; every output is 0 in IDLE.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    cell_en   = 1'b0;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    case (state)
      S_ISSUE1: begin
        cell_en   = 1'b1;
        cell_src1 = a_q;
        cell_src2 = b_q;
      end
      S_ISSUE2: begin
        cell_en   = 1'b1;
        cell_src1 = {16'h0000, a_q[31:16]};
        cell_src2 = {16'h0000, b_q[31:16]};
      end
      default: ;
    endcase
  end

  // Operand latch, partial-product capture and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 2'b00;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      mid_hi_q   <= 17'h0;
      lo_carry_q <= 1'b0;
      result     <= 32'h0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= src1;
        b_q  <= src2;
      end
      if (state == S_WAIT1) begin
        mid_hi_q   <= mid_sum[32:16];
        lo_carry_q <= low_sum[32];
        if (op_q == OP_MUL) begin
          result <= low_sum[31:0];
        end
      end
      if (state == S_WAIT2) begin
        result <= high_word;
      end
    end
  end

endmodule
